// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for the core's load/store unit.
// Accepts one request at a time (req_valid/req_ready), spends WAIT_CYCLES
// cycles in WAIT, commits the access on the edge entering RESP, and holds
// the response (rsp_valid/rsp_ready) until it is taken.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_we                  1 = store, 0 = load
//   req_funct3              RISC-V load/store funct3
//   req_addr, req_wdata     byte address, right-aligned store data
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata, rsp_err      extended load data (0 for stores/errors), fault
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(WAIT_CYCLES + 2);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, commit, mem_we, err;
  logic          a_we;
  logic [2:0]    a_f3;
  logic [31:0]   a_addr, a_wdata;
  logic [29:0]   offset_w;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          is_byte, is_half, is_word, bad_f3;
  logic [31:0]   rd_word, load_data, wr_data;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [3:0]    wr_be;

  // Access decode. With no wait states the commit edge is the accept edge,
  // so the live request is decoded in IDLE; otherwise the latched copy.
  always_comb begin
    accept   = (state_q == S_IDLE) && req_valid && req_ready_q;
    a_we     = (state_q == S_IDLE) ? req_we     : we_q;
    a_f3     = (state_q == S_IDLE) ? req_funct3 : f3_q;
    a_addr   = (state_q == S_IDLE) ? req_addr   : addr_q;
    a_wdata  = (state_q == S_IDLE) ? req_wdata  : wdata_q;

    offset_w = a_addr[31:2] - BASE_ADDR[31:2];
    idx      = offset_w[AW-1:0];
    lane     = a_addr[1:0];

    is_byte  = (a_f3[1:0] == 2'b00);
    is_half  = (a_f3[1:0] == 2'b01);
    is_word  = (a_f3 == 3'b010);
    bad_f3   = (a_f3 == 3'b011) || (a_f3[2:1] == 2'b11);

    err = (offset_w[29:AW] != '0) || bad_f3 || (a_f3[2] && a_we) ||
          (is_half && lane[0]) || (is_word && (lane != 2'b00));

    rd_word = mem[idx];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (a_f3)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'h0, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'h0, rd_half};
      3'b010:  load_data = rd_word;
      default: load_data = '0;
    endcase

    if (is_byte) begin
      wr_be   = 4'b0001 << lane;
      wr_data = {4{a_wdata[7:0]}};
    end else if (is_half) begin
      wr_be   = lane[1] ? 4'b1100 : 4'b0011;
      wr_data = {2{a_wdata[15:0]}};
    end else begin
      wr_be   = 4'b1111;
      wr_data = a_wdata;
    end

    commit = (NO_WAIT && accept) ||
             ((state_q == S_WAIT) && ((cnt_q + CW'(1)) == CW'(WAIT_CYCLES)));
    mem_we = commit && a_we && !err;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = NO_WAIT ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (commit) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err;
      rsp_rdata_d = (err || a_we) ? '0 : load_data;
    end

    // Registered from the next state so ready and valid can never overlap.
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array is never cleared; writes are gated by the FSM, which reset holds in IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 1 and 3 wait
// states share clock and reset; a vector table drives loads/stores and
// faults, followed by backpressure and reset-during-WAIT sequences.
module tb_dmem_responder;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [2:0][2:0]  req_funct3;
  logic [2:0][31:0] req_addr, req_wdata, rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(4096), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]));

  dmem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(4096), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]));

  dmem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(4096), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
    .req_funct3(req_funct3[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]));

  typedef struct {
    int          dut;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ready and valid must never be high together on any instance
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (req_ready[i] && rsp_valid[i]) begin
          n_fail++;
          $display("FAIL overlap dut%0d: req_ready=1 rsp_valid=1 expected not both", i);
        end
      end
    end
  end

  // Called at a negedge. Returns the response captured on the first negedge
  // with rsp_valid, and its latency in cycles from the accept cycle.
  task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int k;
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    k = 0;
    while (!req_ready[d] && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready[d]) begin
      chk("accept_timeout", {31'h0, req_ready[d]}, 32'h1);
      req_valid[d] = 1'b0;
      rdata = 'x;
      err   = 1'bx;
      lat   = -1;
      return;
    end
    @(negedge clk);
    // scribble the request bus; the accepted access must be unaffected
    req_valid[d]  = 1'b0;
    req_we[d]     = ~we;
    req_addr[d]   = ~addr;
    req_wdata[d]  = ~wdata;
    req_funct3[d] = 3'b011;
    lat = 1;
    while (!rsp_valid[d] && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid[d]) lat = -1;
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    if (rsp_ready[d] && rsp_valid[d]) begin
      @(negedge clk);
      chk("handoff_valid_low", {31'h0, rsp_valid[d]}, 32'h0);
      chk("handoff_ready_high", {31'h0, req_ready[d]}, 32'h1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vec [$];
    logic [31:0] rd;
    logic        er;
    int          lat;
    string       nm;

    //        dut we f3      addr           wdata          rdata          err  lat
    vec.push_back('{1, 1, 3'b010, 32'h8000_0010, 32'hDEADBEEF, 32'h0000_0000, 0, 2}); // SW
    vec.push_back('{1, 0, 3'b010, 32'h8000_0010, 32'h0,        32'hDEADBEEF, 0, 2}); // LW
    vec.push_back('{1, 1, 3'b000, 32'h8000_0011, 32'h1234565A, 32'h0000_0000, 0, 2}); // SB
    vec.push_back('{1, 0, 3'b010, 32'h8000_0010, 32'h0,        32'hDEAD5AEF, 0, 2}); // LW
    vec.push_back('{1, 0, 3'b000, 32'h8000_0013, 32'h0,        32'hFFFFFFDE, 0, 2}); // LB
    vec.push_back('{1, 0, 3'b100, 32'h8000_0013, 32'h0,        32'h000000DE, 0, 2}); // LBU
    vec.push_back('{1, 0, 3'b001, 32'h8000_0012, 32'h0,        32'hFFFFDEAD, 0, 2}); // LH
    vec.push_back('{1, 0, 3'b101, 32'h8000_0012, 32'h0,        32'h0000DEAD, 0, 2}); // LHU
    vec.push_back('{1, 0, 3'b010, 32'h8000_0012, 32'h0,        32'h0000_0000, 1, 2}); // LW misaligned
    vec.push_back('{1, 1, 3'b001, 32'h8000_0011, 32'h0000BEEF, 32'h0000_0000, 1, 2}); // SH misaligned
    vec.push_back('{1, 0, 3'b010, 32'h8000_0010, 32'h0,        32'hDEAD5AEF, 0, 2}); // unchanged
    vec.push_back('{1, 0, 3'b010, 32'h7FFF_FFFC, 32'h0,        32'h0000_0000, 1, 2}); // below window
    vec.push_back('{1, 0, 3'b010, 32'h8000_4000, 32'h0,        32'h0000_0000, 1, 2}); // above window
    vec.push_back('{1, 0, 3'b011, 32'h8000_0010, 32'h0,        32'h0000_0000, 1, 2}); // funct3 011
    vec.push_back('{1, 1, 3'b100, 32'h8000_0010, 32'h000000FF, 32'h0000_0000, 1, 2}); // store w/ 100
    vec.push_back('{1, 0, 3'b010, 32'h8000_0010, 32'h0,        32'hDEAD5AEF, 0, 2}); // unchanged
    vec.push_back('{1, 1, 3'b010, 32'h8000_0014, 32'h11223344, 32'h0000_0000, 0, 2}); // SW
    vec.push_back('{1, 1, 3'b001, 32'h8000_0016, 32'h9999A5C3, 32'h0000_0000, 0, 2}); // SH upper
    vec.push_back('{1, 0, 3'b010, 32'h8000_0014, 32'h0,        32'hA5C33344, 0, 2}); // LW
    vec.push_back('{1, 0, 3'b000, 32'h8000_0014, 32'h0,        32'h00000044, 0, 2}); // LB positive
    vec.push_back('{1, 0, 3'b001, 32'h8000_0016, 32'h0,        32'hFFFFA5C3, 0, 2}); // LH
    vec.push_back('{0, 1, 3'b010, 32'h8000_0000, 32'hCAFEF00D, 32'h0000_0000, 0, 1}); // W=0 SW
    vec.push_back('{0, 0, 3'b010, 32'h8000_0000, 32'h0,        32'hCAFEF00D, 0, 1}); // W=0 LW
    vec.push_back('{0, 0, 3'b101, 32'h8000_0002, 32'h0,        32'h0000CAFE, 0, 1}); // W=0 LHU
    vec.push_back('{0, 0, 3'b110, 32'h8000_0000, 32'h0,        32'h0000_0000, 1, 1}); // W=0 funct3 110
    vec.push_back('{2, 1, 3'b010, 32'h8000_0020, 32'hAAAA5555, 32'h0000_0000, 0, 4}); // W=3 SW
    vec.push_back('{2, 0, 3'b010, 32'h8000_0020, 32'h0,        32'hAAAA5555, 0, 4}); // W=3 LW

    reset      = 1'b0;
    req_valid  = '0;
    req_we     = '0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = '1;

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_req_ready%0d", i), {31'h0, req_ready[i]}, 32'h0);
      chk($sformatf("rst_rsp_valid%0d", i), {31'h0, rsp_valid[i]}, 32'h0);
      chk($sformatf("rst_rsp_rdata%0d", i), rsp_rdata[i], 32'h0);
      chk($sformatf("rst_rsp_err%0d", i), {31'h0, rsp_err[i]}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("post_rst_ready%0d", i), {31'h0, req_ready[i]}, 32'h1);

    for (int v = 0; v < vec.size(); v++) begin
      do_req(vec[v].dut, vec[v].we, vec[v].f3, vec[v].addr, vec[v].wdata, rd, er, lat);
      nm = $sformatf("v%0d", v);
      chk({nm, "_rdata"}, rd, vec[v].exp_rdata);
      chk({nm, "_err"}, {31'h0, er}, {31'h0, vec[v].exp_err});
      chk({nm, "_lat"}, lat, vec[v].exp_lat);
    end

    // backpressure on the 1-wait instance
    rsp_ready[1] = 1'b0;
    do_req(1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, rd, er, lat);
    chk("bp_rdata", rd, 32'hDEAD5AEF);
    chk("bp_lat", lat, 2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", c), {31'h0, rsp_valid[1]}, 32'h1);
      chk($sformatf("bp_hold_rdata%0d", c), rsp_rdata[1], 32'hDEAD5AEF);
      chk($sformatf("bp_hold_ready%0d", c), {31'h0, req_ready[1]}, 32'h0);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'h0, rsp_valid[1]}, 32'h0);
    chk("bp_release_ready", {31'h0, req_ready[1]}, 32'h1);

    // reset during WAIT on the 3-wait instance aborts the store
    req_valid[2]  = 1'b1;
    req_we[2]     = 1'b1;
    req_funct3[2] = 3'b010;
    req_addr[2]   = 32'h8000_0020;
    req_wdata[2]  = 32'h12345678;
    chk("abort_ready_before", {31'h0, req_ready[2]}, 32'h1);
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("abort_in_wait", {31'h0, req_ready[2]}, 32'h0);
    chk("abort_rdata_before", rsp_rdata[2], 32'hAAAA5555);
    reset = 1'b0;
    #1;
    chk("abort_async_valid", {31'h0, rsp_valid[2]}, 32'h0);
    chk("abort_async_rdata", rsp_rdata[2], 32'h0);
    chk("abort_async_err", {31'h0, rsp_err[2]}, 32'h0);
    chk("abort_async_ready", {31'h0, req_ready[2]}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("abort_no_rsp%0d", c), {31'h0, rsp_valid[2]}, 32'h0);
    end
    do_req(2, 1'b0, 3'b010, 32'h8000_0020, 32'h0, rd, er, lat);
    chk("abort_mem_kept", rd, 32'hAAAA5555);
    chk("abort_mem_err", {31'h0, er}, 32'h0);
    chk("abort_mem_lat", lat, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-mapped data-memory responder: the target end of the core's load/store interface.
- Accepts one load or store request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Performs byte, halfword or word access with RISC-V funct3 semantics, then returns a response over a second valid/ready handshake.
- Sits behind the multi-cycle core's LSU as the backing RAM for the data address window.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of the first word in the window.
- DEPTH_WORDS, 4096, number of 32-bit words; power of two.
- WAIT_CYCLES, 1, cycles spent in WAIT between accept and response; 0 is legal.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  access type, RISC-V load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts the response
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- rsp_err  out  1  access faulted

Behaviour:
- Reset is asynchronous and active-low; it is not a synchronous clear. While reset = 0:
  - state = IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
  - The memory array is not cleared.
- After reset releases, req_ready = 1 from the first clk edge.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch we, funct3, addr and wdata.
  - Go to WAIT if WAIT_CYCLES > 0, otherwise go to RESP.
- WAIT:
  - req_ready = 0; the counter counts 1..WAIT_CYCLES.
  - Go to RESP on the edge where the count equals WAIT_CYCLES.
- RESP entry edge (commit):
  - Stores write the memory on this edge.
  - rsp_valid, rsp_rdata and rsp_err are registered on this edge.
- RESP:
  - rsp_valid = 1 and req_ready = 0.
  - rsp_rdata and rsp_err hold stable until rsp_ready = 1.
  - On rsp_valid & rsp_ready, go to IDLE and drop rsp_valid on that edge.
- Latency: accept-to-rsp_valid = WAIT_CYCLES + 1 cycles. With WAIT_CYCLES = 0 and rsp_ready tied to 1, throughput is one access per 2 cycles.
- Address decode:
  - offset = addr - BASE_ADDR.
  - Word index = offset[log2(DEPTH_WORDS)+1:2].
  - In range only if BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
- funct3 decode:
  - 000 = byte, signed load
  - 001 = half, signed load
  - 010 = word
  - 100 = byte, zero-extended (load only)
  - 101 = half, zero-extended (load only)
- Byte lanes are little-endian: lane = addr[1:0].
- Stores:
  - SB writes only lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and +1 with wdata[15:0].
  - SW writes all 4 lanes.
  - Other lanes are untouched.
- Loads:
  - The selected byte or half is shifted to bit 0.
  - It is sign-extended for 000/001 and zero-extended for 100/101.
- Error (rsp_err = 1, rsp_rdata = 0, no memory write) on any of:
  - out-of-range address;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - funct3 in {011, 110, 111};
  - funct3 in {100, 101} with we = 1.
- req_* inputs are ignored outside an IDLE accept; a changing req_addr during WAIT has no effect.
- req_ready and rsp_valid are never both 1.
- Reset asserted in WAIT aborts the access: no memory write occurs and no response is issued.
- Reset asserted in RESP drops the response; a store already committed stays written.

Test Plan:
- Basic store/load, WAIT_CYCLES = 1, rsp_ready = 1:
  - SW 0xDEADBEEF to 0x8000_0010, then LW 0x8000_0010 -> rdata 0xDEADBEEF, err 0.
  - rsp_valid rises exactly 2 cycles after each accept.
- Sub-word loads and stores:
  - After the word above, SB 0x5A to 0x8000_0011, then LW -> 0xDEAD5AEF.
  - LB 0x8000_0013 -> 0xFFFFFFDE.
  - LBU 0x8000_0013 -> 0x000000DE.
  - LH 0x8000_0012 -> 0xFFFFDEAD.
  - LHU 0x8000_0012 -> 0x0000DEAD.
- Faults:
  - LW 0x8000_0012 -> err 1, rdata 0.
  - SH 0x8000_0011 -> err 1 and the word is unchanged.
  - LW 0x7FFF_FFFC -> err 1.
  - LW 0x8000_4000 (DEPTH 4096) -> err 1.
  - funct3 = 011 -> err 1.
  - SB issued with funct3 = 100 -> err 1.
- Backpressure:
  - Hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0.
  - Raise rsp_ready -> one-cycle handshake, then req_ready = 1 on the next cycle.
- Wait-state sweep:
  - WAIT_CYCLES = 0 -> latency 1 cycle.
  - WAIT_CYCLES = 3 -> latency 4 cycles.
  - Back-to-back requests with rsp_ready = 1 never overlap.
- Reset mid-access:
  - Issue SW 0x12345678 to 0x8000_0020 with WAIT_CYCLES = 3.
  - Pulse reset low during WAIT -> outputs zero immediately (asynchronous), no response.
  - Subsequent LW 0x8000_0020 returns the prior contents, not 0x12345678.
